// File: rtl/control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : control_fsm_if
// Purpose  : Bundles the instruction handshake, the memory request/ack
//            handshake and the datapath control strobes of the pierogi
//            multi-cycle control sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   OPW  - opcode width (>= 4)
//   ALUW - alu_op width (>= 4)
// Signals:
//   instr_valid / instr_ready / opcode  - instruction handshake from fetch
//   eq                                  - datapath comparator equal flag
//   mem_req / mem_we / mem_ack          - memory request handshake
//   rf_we, pc_load, pc_jump, b_sel,
//   wb_sel, alu_op                      - datapath controls
//   illegal, fault                      - status
// Modports:
//   master - the control sequencer (drives controls, consumes opcode/flags)
//   slave  - the fetch/datapath/memory environment around it
// ============================================================================
interface control_fsm_if #(
  parameter int OPW  = 4,
  parameter int ALUW = 4
);
  logic            instr_valid;
  logic            instr_ready;
  logic [OPW-1:0]  opcode;
  logic            eq;
  logic            mem_ack;
  logic            mem_req;
  logic            mem_we;
  logic            rf_we;
  logic            pc_load;
  logic            pc_jump;
  logic            b_sel;
  logic            wb_sel;
  logic [ALUW-1:0] alu_op;
  logic            illegal;
  logic            fault;

  modport master (
    input  instr_valid, opcode, eq, mem_ack,
    output instr_ready, mem_req, mem_we, rf_we, pc_load, pc_jump,
           b_sel, wb_sel, alu_op, illegal, fault
  );

  modport slave (
    output instr_valid, opcode, eq, mem_ack,
    input  instr_ready, mem_req, mem_we, rf_we, pc_load, pc_jump,
           b_sel, wb_sel, alu_op, illegal, fault
  );
endinterface
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : control_fsm
// Purpose  : Multi-cycle control sequencer for the pierogi CPU. Accepts one
//            opcode at a time and walks it through DECODE, EXEC, MEM and WB,
//            driving registered datapath selects, ALU op, register-file
//            write, PC load and a stall-capable memory request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   OPW     - opcode width, >= 4 (only bits [3:0] encode operations);
//             must match the connected interface instance
//   ALUW    - alu_op width, >= 4 (upper bits driven 0); must match interface
//   TIMEOUT - maximum MEM wait cycles (1..255), only with CTRL_TIMEOUT_EN
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - control_fsm_if.master (instruction, memory and control signals)
// Configuration macro:
//   CTRL_TIMEOUT_EN - when defined, a MEM wait longer than TIMEOUT cycles
//                     sets the sticky fault and parks the sequencer in HALT.
//                     When undefined, MEM waits forever and fault is 0.
// Notes:
//   Every output is a flop; each one is loaded with the value belonging to
//   the state being entered, so nothing combinational reaches the ports.
// ============================================================================
module control_fsm #(
  parameter int OPW     = 4,
  parameter int ALUW    = 4,
  parameter int TIMEOUT = 15
) (
  input wire            clk,
  input wire            rst,
  control_fsm_if.master bus
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  generate
    if (OPW < 4 || ALUW < 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
      $error("control_fsm: OPW/ALUW must be >= 4 and TIMEOUT in 1..255");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Opcode values with a control-flow meaning of their own
  localparam logic [3:0] c_op_j   = 4'h7;
  localparam logic [3:0] c_op_beq = 4'h8;
  localparam logic [3:0] c_op_bne = 4'h9;
  localparam logic [3:0] c_op_lw  = 4'hE;
  localparam logic [3:0] c_op_sw  = 4'hF;

  state_t          r_state, w_state_nx;
  logic [3:0]      r_op, w_op_nx;
  logic            r_ready, w_ready_nx;
  logic            r_mem_req, w_mem_req_nx;
  logic            r_mem_we, w_mem_we_nx;
  logic            r_rf_we, w_rf_we_nx;
  logic            r_pc_load, w_pc_load_nx;
  logic            r_pc_jump, w_pc_jump_nx;
  logic            r_b_sel, w_b_sel_nx;
  logic            r_wb_sel, w_wb_sel_nx;
  logic [ALUW-1:0] r_alu_op, w_alu_op_nx;
  logic            r_illegal, w_illegal_nx;

`ifdef CTRL_TIMEOUT_EN
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);
  logic [7:0] r_wait_cnt, w_wait_cnt_nx;
  logic       r_fault, w_fault_nx;
`endif

  // --------------------------------------------------------------------------
  // Opcode bits above [3:0] mark an unsupported instruction
  // --------------------------------------------------------------------------
  logic w_op_hi;
  generate
    if (OPW > 4) begin : g_op_hi
      assign w_op_hi = |bus.opcode[OPW-1:4];
    end else begin : g_op_narrow
      assign w_op_hi = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Select decode of the incoming opcode. Loaded at the accept edge so the
  // selects are already valid in the first DECODE cycle.
  // --------------------------------------------------------------------------
  logic [3:0] w_dec_alu;
  logic       w_dec_b_sel;
  logic       w_dec_wb_sel;
  logic       w_dec_pc_jump;

  always_comb begin
    w_dec_alu     = 4'h0;
    w_dec_b_sel   = 1'b0;
    w_dec_wb_sel  = 1'b0;
    w_dec_pc_jump = 1'b0;
    case (bus.opcode[3:0])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
        w_dec_alu    = bus.opcode[3:0];
        w_dec_wb_sel = 1'b1;
      end
      4'h7: begin
        w_dec_pc_jump = 1'b1;
      end
      4'h8, 4'h9: begin
        // Branches are PC-relative; the comparator needs no ALU setting.
        w_dec_pc_jump = 1'b0;
      end
      4'hA, 4'hB: begin
        w_dec_alu    = bus.opcode[3:0];
        w_dec_b_sel  = 1'b1;
        w_dec_wb_sel = 1'b1;
      end
      4'hC: begin
        w_dec_alu    = 4'h4;
        w_dec_b_sel  = 1'b1;
        w_dec_wb_sel = 1'b1;
      end
      4'hD: begin
        w_dec_alu    = 4'hC;
        w_dec_wb_sel = 1'b1;
      end
      4'hE, 4'hF: begin
        // Address = base + immediate; write-back comes from memory.
        w_dec_alu   = 4'h4;
        w_dec_b_sel = 1'b1;
      end
      default: begin
        w_dec_alu = 4'h0;
      end
    endcase
  end

  // Class of the latched opcode, used from EXEC onward
  logic w_is_ctl;
  logic w_is_mem;
  assign w_is_ctl = (r_op == c_op_j) || (r_op == c_op_beq) || (r_op == c_op_bne);
  assign w_is_mem = (r_op == c_op_lw) || (r_op == c_op_sw);

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx   = r_state;
    w_op_nx      = r_op;
    w_alu_op_nx  = r_alu_op;
    w_b_sel_nx   = r_b_sel;
    w_wb_sel_nx  = r_wb_sel;
    w_pc_jump_nx = r_pc_jump;
    w_illegal_nx = 1'b0;
    w_rf_we_nx   = 1'b0;
    w_pc_load_nx = 1'b0;
    w_mem_req_nx = 1'b0;
    w_mem_we_nx  = 1'b0;
    w_ready_nx   = 1'b0;
`ifdef CTRL_TIMEOUT_EN
    w_wait_cnt_nx = r_wait_cnt;
    w_fault_nx    = r_fault;
`endif

    case (r_state)
      S_FETCH: begin
        if (bus.instr_valid && r_ready) begin
          w_op_nx    = bus.opcode[3:0];
          w_state_nx = S_DECODE;
          if (w_op_hi) begin
            // Selects stay at their FETCH value of 0.
            w_illegal_nx = 1'b1;
          end else begin
            w_alu_op_nx  = ALUW'(w_dec_alu);
            w_b_sel_nx   = w_dec_b_sel;
            w_wb_sel_nx  = w_dec_wb_sel;
            w_pc_jump_nx = w_dec_pc_jump;
          end
        end
      end

      S_DECODE: begin
        if (r_illegal) begin
          w_state_nx = S_FETCH;
        end else begin
          w_state_nx = S_EXEC;
          // pc_load is a flop that must be high during EXEC, so the branch
          // decision uses the comparator flag present at the edge entering
          // EXEC; the datapath holds eq stable across that boundary.
          case (r_op)
            c_op_j:   w_pc_load_nx = 1'b1;
            c_op_beq: w_pc_load_nx = bus.eq;
            c_op_bne: w_pc_load_nx = ~bus.eq;
            default:  w_pc_load_nx = 1'b0;
          endcase
        end
      end

      S_EXEC: begin
        if (w_is_ctl) begin
          w_state_nx = S_FETCH;
        end else if (w_is_mem) begin
          w_state_nx   = S_MEM;
          w_mem_req_nx = 1'b1;
          w_mem_we_nx  = (r_op == c_op_sw);
`ifdef CTRL_TIMEOUT_EN
          w_wait_cnt_nx = 8'd0;
`endif
        end else begin
          w_state_nx = S_WB;
          w_rf_we_nx = 1'b1;
        end
      end

      S_MEM: begin
        // An ack in the expiry cycle is honoured before the timeout.
        if (bus.mem_ack) begin
          if (r_op == c_op_lw) begin
            w_state_nx = S_WB;
            w_rf_we_nx = 1'b1;
          end else begin
            w_state_nx = S_FETCH;
          end
        end else begin
`ifdef CTRL_TIMEOUT_EN
          if (r_wait_cnt == c_wait_last) begin
            w_state_nx = S_HALT;
            w_fault_nx = 1'b1;
          end else begin
            w_wait_cnt_nx = r_wait_cnt + 8'd1;
            w_mem_req_nx  = 1'b1;
            w_mem_we_nx   = (r_op == c_op_sw);
          end
`else
          w_mem_req_nx = 1'b1;
          w_mem_we_nx  = (r_op == c_op_sw);
`endif
        end
      end

      S_WB: begin
        w_state_nx = S_FETCH;
      end

      S_HALT: begin
        w_state_nx = S_HALT;
      end

      default: begin
        w_state_nx = S_FETCH;
      end
    endcase

    // Selects are meaningful only while an instruction is in flight.
    if (w_state_nx == S_FETCH || w_state_nx == S_HALT) begin
      w_alu_op_nx  = '0;
      w_b_sel_nx   = 1'b0;
      w_wb_sel_nx  = 1'b0;
      w_pc_jump_nx = 1'b0;
    end

    w_ready_nx = (w_state_nx == S_FETCH);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= 4'h0;
      r_ready   <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_rf_we   <= 1'b0;
      r_pc_load <= 1'b0;
      r_pc_jump <= 1'b0;
      r_b_sel   <= 1'b0;
      r_wb_sel  <= 1'b0;
      r_alu_op  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_op      <= w_op_nx;
      r_ready   <= w_ready_nx;
      r_mem_req <= w_mem_req_nx;
      r_mem_we  <= w_mem_we_nx;
      r_rf_we   <= w_rf_we_nx;
      r_pc_load <= w_pc_load_nx;
      r_pc_jump <= w_pc_jump_nx;
      r_b_sel   <= w_b_sel_nx;
      r_wb_sel  <= w_wb_sel_nx;
      r_alu_op  <= w_alu_op_nx;
      r_illegal <= w_illegal_nx;
    end
  end

`ifdef CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= 8'd0;
      r_fault    <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nx;
      r_fault    <= w_fault_nx;
    end
  end
  assign bus.fault = r_fault;
`else
  assign bus.fault = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Port drive
  // --------------------------------------------------------------------------
  assign bus.instr_ready = r_ready;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.rf_we       = r_rf_we;
  assign bus.pc_load     = r_pc_load;
  assign bus.pc_jump     = r_pc_jump;
  assign bus.b_sel       = r_b_sel;
  assign bus.wb_sel      = r_wb_sel;
  assign bus.alu_op      = r_alu_op;
  assign bus.illegal     = r_illegal;

endmodule
`default_nettype wire

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control sequencer for the pierogi CPU. Accepts one instruction opcode at a time over a valid/ready handshake and walks it through DECODE, EXEC, MEM and WB states. In each state it drives registered datapath selects, the ALU op, register-file write, PC load and a memory request/acknowledge handshake. It sits between instruction fetch and the datapath, and generalises opcode/ALU width while adding a stall-capable memory interface.

## Interface
- OPW, 4: opcode width, must be ≥ 4; only bits [3:0] encode operations.
- ALUW, 4: alu_op width, must be ≥ 4; upper bits driven 0.
- TIMEOUT, 15: maximum MEM wait cycles, used only with CTRL_TIMEOUT_EN; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- instr_valid  in  1  opcode is valid
- instr_ready  out  1  controller can accept (high only in FETCH)
- opcode  in  OPW  instruction opcode
- eq  in  1  datapath comparator equal flag
- mem_ack  in  1  memory transfer complete
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  store qualifier, valid with mem_req
- rf_we  out  1  register-file write pulse
- pc_load  out  1  PC load pulse
- pc_jump  out  1  1 = absolute target, 0 = PC-relative
- b_sel  out  1  1 = immediate operand B, 0 = register
- wb_sel  out  1  1 = ALU result, 0 = memory data
- alu_op  out  ALUW  ALU function
- illegal  out  1  one-cycle pulse on an unsupported opcode
- fault  out  1  sticky memory timeout

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state is FETCH. All outputs reset to 0.
- FETCH: instr_ready=1. When instr_valid is high, opcode is latched and the state moves to DECODE. Otherwise the state stays in FETCH.
- DECODE: alu_op, b_sel, wb_sel and pc_jump are registered from the latched opcode. They stay stable until the return to FETCH, and are 0 in FETCH.
- If any latched bit above bit 3 is set: illegal=1 for one cycle, then FETCH. Nothing else is asserted.
- Opcode map, bits [3:0]:
  - 0–6 are and/or/xor/not/add/sub/cmp: alu_op = opcode, b_sel=0, wb_sel=1.
  - A = sl, B = sr: alu_op = opcode, b_sel=1, wb_sel=1.
  - C = addi: alu_op=4, b_sel=1, wb_sel=1.
  - D = lui: alu_op=C, b_sel=0, wb_sel=1.
  - 7 = j, 8 = beq, 9 = bne.
  - E = lw, F = sw: alu_op=4 for address, b_sel=1, wb_sel=0.
- EXEC, by opcode class:
  - ALU ops go to WB.
  - j: pc_jump=1 and pc_load=1 this cycle, then FETCH.
  - beq/bne: eq is sampled this cycle. pc_load = eq for beq and ~eq for bne, pc_jump=0, then FETCH.
  - lw/sw go to MEM.
- MEM: mem_req=1, and mem_we=1 for sw only. The state holds until mem_ack=1 is sampled, and mem_req drops on the following edge. Then lw goes to WB and sw goes to FETCH.
- WB: rf_we=1 for exactly one cycle, then FETCH.
- mem_ack outside MEM is ignored. eq outside EXEC is ignored.
- An async rst during any state returns to FETCH immediately. mem_req and rf_we drop without waiting for a clock, and fault clears.

## Timing
- Cycle numbering: accept edge = cycle 0 (instr_valid && instr_ready).
- ALU op: DECODE at c1, EXEC at c2, rf_we high during c3, instr_ready again at c4.
- Branches and jump: pc_load high during c2, instr_ready at c3.
- lw: mem_req rises at c3. With ack sampled in cycle k, WB is at k+1 and instr_ready at k+2.
- sw: with ack sampled at k, instr_ready at k+1.
- Zero-wait memory (mem_ack high in the first MEM cycle) gives exactly one mem_req cycle.
- Illegal opcode: illegal high during c1, instr_ready at c2.
- All outputs are registered; no combinational path from any input to any output.

## Configuration
- CTRL_TIMEOUT_EN defined:
  - A counter clears on MEM entry and increments on each MEM cycle without ack.
  - After TIMEOUT cycles without ack, mem_req drops, fault is set and the state goes to HALT.
  - HALT holds with instr_ready=0 and all strobes 0 until rst.
  - If mem_ack arrives in the same cycle as expiry, the ack wins and there is no fault.
- CTRL_TIMEOUT_EN undefined: MEM waits indefinitely, fault is tied 0 and HALT is unreachable.

## Test plan
- Reset, then opcode 4'h4 (add) accepted: alu_op=4, b_sel=0, wb_sel=1 from c1; rf_we high only in c3; instr_ready high at c4.
- beq (8) with eq=1, then bne (9) with eq=1: first gives pc_load=1 at c2 with pc_jump=0; second gives pc_load never asserted; both return to FETCH at c3.
- sw (F) with mem_ack delayed 3 cycles: mem_req and mem_we high for 4 cycles; no rf_we; instr_ready one cycle after ack.
- OPW=6, opcode 6'h14: illegal pulses for 1 cycle; no rf_we, pc_load or mem_req; next instruction accepted at c2.
- CTRL_TIMEOUT_EN with TIMEOUT=4, lw with mem_ack never asserted: fault=1 after 4 MEM cycles, mem_req=0, instr_ready stays 0. Then rst gives all outputs 0 and FETCH.
- Async rst asserted mid-MEM (mem_req=1): mem_req falls before the next clock edge; after release, instr_ready=1.
